// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache refill read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_arb_pkg;

  // Arbiter FSM: wait for a request, present the address, stream the burst
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int M0_IDX = 0;  // I-cache refill master
  localparam int M1_IDX = 1;  // D-cache refill master

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;

endpackage

// File: rtl/cache_arb_pick.sv
// Two-request picker; fixed priority (master 1 first) or round-robin when ARB_RR_EN is defined.
// Latency: combinational pick; the round-robin history register updates on the grant edge.
// Backpressure: none; the caller samples o_grant_idx only when it accepts a request.
module cache_arb_pick
  import cache_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic i_upd,
`endif
  input  logic i_req0,
  input  logic i_req1,
  output logic o_grant_idx
);

`ifdef ARB_RR_EN
  logic r_last_grant;

  // Remember which master won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
    end else if (i_upd) begin
      r_last_grant <= o_grant_idx;
    end
  end

  // On contention the master that did not win last time goes first
  always_comb begin
    o_grant_idx = 1'(M0_IDX);
    if (i_req0 && i_req1) begin
      o_grant_idx = ~r_last_grant;
    end else if (i_req1) begin
      o_grant_idx = 1'(M1_IDX);
    end
  end
`else
  // D-cache refill always beats the I-cache refill on contention
  always_comb begin
    o_grant_idx = 1'(M0_IDX);
    if (i_req1) begin
      o_grant_idx = 1'(M1_IDX);
    end else if (i_req0) begin
      o_grant_idx = 1'(M0_IDX);
    end
  end
`endif

endmodule

// File: rtl/cache_rd_arbiter.sv
// Grants the shared burst read port to the I-cache (m0) or D-cache (m1) refill, one whole burst at a time.
// Latency: request to arvalid 1 cycle (registered); read data/valid/last/ready pass through combinationally.
// Backpressure: arvalid held until arready; rready mirrors the owner's rready. Optional ARB_RR_EN selects round-robin.
module cache_rd_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int DATA_W = cache_arb_pkg::DATA_W,
  parameter int LEN_W  = cache_arb_pkg::LEN_W,
  parameter int ID_W   = cache_arb_pkg::ID_W,
  parameter int M0_ID  = 0,
  parameter int M1_ID  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0: I-cache refill
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1: D-cache refill
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // shared downstream read port
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [ID_W-1:0]   arid,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // status
  output logic              len_err,
  output logic              busy
);
  import cache_arb_pkg::*;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_grant;
  logic [ADDR_W-1:0] r_araddr;
  logic [LEN_W-1:0]  r_arlen;
  logic [2:0]        r_arsize;
  logic [ID_W-1:0]   r_arid;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic              r_beat_ovf;
  logic              r_len_err;

  logic              w_any_req;
  logic              w_grant_idx;
  logic              w_take;
  logic              w_sel_rready;
  logic              w_r_hs;

  assign w_any_req    = m0_arvalid | m1_arvalid;
  assign w_take       = (r_state == IDLE) & w_any_req;
  assign w_sel_rready = (r_grant == 1'(M1_IDX)) ? m1_rready : m0_rready;
  assign w_r_hs       = (r_state == DATA) & rvalid & w_sel_rready;

  cache_arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk         (clk),
    .rst_n       (rst_n),
    .i_upd       (w_take),
`endif
    .i_req0      (m0_arvalid),
    .i_req1      (m1_arvalid),
    .o_grant_idx (w_grant_idx)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus handshake steering; nothing reaches a master outside its own phase
  always_comb begin
    w_state_nxt = r_state;
    arvalid     = 1'b0;
    rready      = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rlast    = 1'b0;
    m1_rlast    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (r_grant == 1'(M1_IDX)) begin
          m1_arready = arready;
        end else begin
          m0_arready = arready;
        end
        if (arready) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        rready = w_sel_rready;
        if (r_grant == 1'(M1_IDX)) begin
          m1_rvalid = rvalid;
          m1_rlast  = rlast;
        end else begin
          m0_rvalid = rvalid;
          m0_rlast  = rlast;
        end
        if (w_r_hs && rlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winning request, count beats and flag malformed bursts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 1'b0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arid     <= '0;
      r_beat_cnt <= '0;
      r_beat_ovf <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_take) begin
        r_grant <= w_grant_idx;
        if (w_grant_idx == 1'(M1_IDX)) begin
          r_araddr <= m1_araddr;
          r_arlen  <= m1_arlen;
          r_arsize <= m1_arsize;
          r_arid   <= ID_W'(M1_ID);
        end else begin
          r_araddr <= m0_araddr;
          r_arlen  <= m0_arlen;
          r_arsize <= m0_arsize;
          r_arid   <= ID_W'(M0_ID);
        end
      end
      if (r_state == ADDR && arready) begin
        r_beat_cnt <= '0;
        r_beat_ovf <= 1'b0;
      end
      // The counter holds the index of the beat being accepted, so on the
      // final beat it equals arlen and never wraps; extra non-last beats
      // past arlen are remembered in r_beat_ovf instead.
      if (w_r_hs) begin
        if (rlast) begin
          if (r_beat_ovf || (r_beat_cnt != r_arlen) || (rid != r_arid)) begin
            r_len_err <= 1'b1;
          end
        end else if (r_beat_cnt == r_arlen) begin
          r_beat_ovf <= 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign araddr   = r_araddr;
  assign arlen    = r_arlen;
  assign arsize   = r_arsize;
  assign arid     = r_arid;
  assign m0_rdata = rdata;
  assign m1_rdata = rdata;
  assign len_err  = r_len_err;
  assign busy     = (r_state != IDLE);

endmodule
